// File: rtl/wb_multiport_stage_pkg.sv
// Shared types and helpers for the writeback stage: default widths, the buffered
// write record, and the lane popcount/compaction functions.
package wb_pkg;

  localparam int WB_DBITS     = 32;
  localparam int WB_REGNOBITS = 5;
  localparam int WB_LANES     = 2;
  localparam int WB_WPORTS    = 1;
  localparam int WB_DEPTH     = 4;
  localparam int WB_QPORTS    = 2;

  typedef struct packed {
    logic [WB_REGNOBITS-1:0] regno;
    logic [WB_DBITS-1:0]     val;
  } wb_wr_t;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  // Slot a lane lands in when the enqueued lanes are packed together in lane order.
  function automatic int compact_slot(input logic [31:0] mask, input int lane);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (i < lane) n += int'(mask[i]);
    return n;
  endfunction

endpackage

// File: rtl/wb_multiport_stage_if.sv
// Bus between MEM, the writeback stage and DE: retiring lanes in, register-file
// writes out, and the forwarding query ports.
interface wb_multiport_stage_if import wb_pkg::*; #(
  parameter int DBITS     = WB_DBITS,
  parameter int REGNOBITS = WB_REGNOBITS,
  parameter int LANES     = WB_LANES,
  parameter int WPORTS    = WB_WPORTS,
  parameter int QPORTS    = WB_QPORTS
);
  logic [LANES-1:0]            in_valid;
  logic [LANES-1:0]            in_wr_reg;
  logic [LANES*REGNOBITS-1:0]  in_wregno;
  logic [LANES*DBITS-1:0]      in_regval;
  logic                        in_ready;
  logic [WPORTS-1:0]           wr_en;
  logic [WPORTS*REGNOBITS-1:0] wr_regno;
  logic [WPORTS*DBITS-1:0]     wr_val;
  logic [QPORTS*REGNOBITS-1:0] q_regno;
  logic [QPORTS-1:0]           q_hit;
  logic [QPORTS*DBITS-1:0]     q_val;

  modport master (
    output in_valid, in_wr_reg, in_wregno, in_regval, q_regno,
    input  in_ready, wr_en, wr_regno, wr_val, q_hit, q_val
  );

  modport slave (
    input  in_valid, in_wr_reg, in_wregno, in_regval, q_regno,
    output in_ready, wr_en, wr_regno, wr_val, q_hit, q_val
  );
endinterface

// File: rtl/wb_multiport_stage_wrbuf.sv
// In-order circular write buffer: up to LANES pushes and WPORTS pops per cycle,
// head window for draining, and a youngest-wins associative search per query port.
module wb_wrbuf #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int LANES     = 2,
  parameter int WPORTS    = 1,
  parameter int DEPTH     = 4,
  parameter int QPORTS    = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [$clog2(DEPTH+1)-1:0]           push_cnt,
  input  logic [REGNOBITS+DBITS-1:0]           push_data [LANES],
  input  logic [$clog2(DEPTH+1)-1:0]           pop_cnt,
  output logic [REGNOBITS+DBITS-1:0]           head_data [WPORTS],
  output logic [$clog2(DEPTH+1)-1:0]           count,
  input  logic [REGNOBITS-1:0]                 s_regno [QPORTS],
  output logic [QPORTS-1:0]                    s_hit,
  output logic [DBITS-1:0]                     s_val [QPORTS]
);
  localparam int W  = REGNOBITS + DBITS;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head, tail;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % DEPTH);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= wrap_add(head, int'(pop_cnt));
      tail  <= wrap_add(tail, int'(push_cnt));
      count <= count + push_cnt - pop_cnt;
    end
  end

  // NOTE: the storage array has no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (i < int'(push_cnt)) mem[wrap_add(tail, i)] <= push_data[i];
  end

  always_comb begin
    for (int p = 0; p < WPORTS; p++) head_data[p] = mem[wrap_add(head, p)];
  end

  // Scan oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    s_hit = '0;
    for (int q = 0; q < QPORTS; q++) begin
      s_val[q] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (i < int'(count) && mem[wrap_add(head, i)][W-1 -: REGNOBITS] == s_regno[q]) begin
          s_hit[q] = 1'b1;
          s_val[q] = mem[wrap_add(head, i)][DBITS-1:0];
        end
      end
    end
  end
endmodule

// File: rtl/wb_multiport_stage.sv
// Writeback stage top: filters and compacts retiring lanes into the write buffer,
// drains it to the register file with same-register suppression, and forwards to DE.
module wb_multiport_stage import wb_pkg::*; #(
  parameter int DBITS     = WB_DBITS,
  parameter int REGNOBITS = WB_REGNOBITS,
  parameter int LANES     = WB_LANES,
  parameter int WPORTS    = WB_WPORTS,
  parameter int DEPTH     = WB_DEPTH,
  parameter int QPORTS    = WB_QPORTS
) (
  input  logic                       clk,
  input  logic                       reset,
  wb_multiport_stage_if.slave        bus,
  output logic [31:0]                retired_count,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = REGNOBITS + DBITS;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0]     enq_mask;
  logic [CW-1:0]        push_cnt, pop_cnt;
  logic [W-1:0]         push_data [LANES];
  logic [W-1:0]         head_data [WPORTS];
  logic [REGNOBITS-1:0] s_regno [QPORTS];
  logic [QPORTS-1:0]    s_hit;
  logic [DBITS-1:0]     s_val [QPORTS];

  // Readiness looks only at pre-edge occupancy; a same-cycle drain does not help.
  assign bus.in_ready = (DEPTH - int'(buf_count)) >= LANES;
  assign pop_cnt      = (int'(buf_count) < WPORTS) ? buf_count : CW'(WPORTS);
  assign push_cnt     = CW'(popcount(32'(enq_mask)));

  // NOTE: every combinational output gets a default first so no path leaves it holding a value.
  always_comb begin
    enq_mask = '0;
    for (int l = 0; l < LANES; l++) push_data[l] = '0;
    for (int l = 0; l < LANES; l++) begin
      enq_mask[l] = bus.in_ready && bus.in_valid[l] && bus.in_wr_reg[l] &&
                    (bus.in_wregno[l*REGNOBITS +: REGNOBITS] != '0);
    end
    for (int l = 0; l < LANES; l++) begin
      if (enq_mask[l])
        push_data[LW'(compact_slot(32'(enq_mask), l))] =
          {bus.in_wregno[l*REGNOBITS +: REGNOBITS], bus.in_regval[l*DBITS +: DBITS]};
    end
  end

  wb_wrbuf #(
    .DBITS(DBITS), .REGNOBITS(REGNOBITS), .LANES(LANES),
    .WPORTS(WPORTS), .DEPTH(DEPTH), .QPORTS(QPORTS)
  ) u_wrbuf (
    .clk       (clk),
    .reset     (reset),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .head_data (head_data),
    .count     (buf_count),
    .s_regno   (s_regno),
    .s_hit     (s_hit),
    .s_val     (s_val)
  );

  // An older presented entry is silenced when a younger presented one targets the same register.
  always_comb begin
    bus.wr_en    = '0;
    bus.wr_regno = '0;
    bus.wr_val   = '0;
    for (int p = 0; p < WPORTS; p++) begin
      if (p < int'(pop_cnt)) begin
        bus.wr_regno[p*REGNOBITS +: REGNOBITS] = head_data[p][W-1 -: REGNOBITS];
        bus.wr_val[p*DBITS +: DBITS]           = head_data[p][DBITS-1:0];
        bus.wr_en[p]                           = 1'b1;
        for (int y = p + 1; y < WPORTS; y++) begin
          if (y < int'(pop_cnt) && head_data[y][W-1 -: REGNOBITS] == head_data[p][W-1 -: REGNOBITS])
            bus.wr_en[p] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.q_hit = '0;
    bus.q_val = '0;
    for (int q = 0; q < QPORTS; q++) begin
      s_regno[q] = bus.q_regno[q*REGNOBITS +: REGNOBITS];
      if (s_hit[q] && s_regno[q] != '0) begin
        bus.q_hit[q]                 = 1'b1;
        bus.q_val[q*DBITS +: DBITS]  = s_val[q];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_count <= '0;
    else if (bus.in_ready) retired_count <= retired_count + 32'(popcount(32'(bus.in_valid)));
  end
endmodule

// File: tb/tb_wb_multiport_stage.sv
// Scoreboard bench for wb_multiport_stage: one WPORTS=1 and one WPORTS=2 instance share
// stimulus; a queue-based reference model predicts each cycle, a monitor compares.
module tb_wb_multiport_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_valid, in_wr_reg;
  logic [9:0]  in_wregno;
  logic [63:0] in_regval;
  logic [9:0]  q_regno;

  wb_multiport_stage_if #(.WPORTS(1)) if_a ();
  wb_multiport_stage_if #(.WPORTS(2)) if_b ();

  assign if_a.in_valid  = in_valid;
  assign if_a.in_wr_reg = in_wr_reg;
  assign if_a.in_wregno = in_wregno;
  assign if_a.in_regval = in_regval;
  assign if_a.q_regno   = q_regno;
  assign if_b.in_valid  = in_valid;
  assign if_b.in_wr_reg = in_wr_reg;
  assign if_b.in_wregno = in_wregno;
  assign if_b.in_regval = in_regval;
  assign if_b.q_regno   = q_regno;

  logic [31:0] ret_a, ret_b;
  logic [2:0]  cnt_a, cnt_b;

  wb_multiport_stage #(.WPORTS(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .retired_count(ret_a), .buf_count(cnt_a));
  wb_multiport_stage #(.WPORTS(2)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .retired_count(ret_b), .buf_count(cnt_b));

  always #5 clk = ~clk;

  // Uniform views of both instances for the monitor.
  logic [1:0]  d_en    [2];
  logic [9:0]  d_regno [2];
  logic [63:0] d_val   [2];
  logic        d_ready [2];
  logic [2:0]  d_cnt   [2];
  logic [31:0] d_ret   [2];
  logic [1:0]  d_qhit  [2];
  logic [63:0] d_qval  [2];

  assign d_en[0]    = {1'b0, if_a.wr_en};
  assign d_regno[0] = {5'd0, if_a.wr_regno};
  assign d_val[0]   = {32'd0, if_a.wr_val};
  assign d_en[1]    = if_b.wr_en;
  assign d_regno[1] = if_b.wr_regno;
  assign d_val[1]   = if_b.wr_val;
  assign d_ready[0] = if_a.in_ready;
  assign d_ready[1] = if_b.in_ready;
  assign d_cnt[0]   = cnt_a;
  assign d_cnt[1]   = cnt_b;
  assign d_ret[0]   = ret_a;
  assign d_ret[1]   = ret_b;
  assign d_qhit[0]  = if_a.q_hit;
  assign d_qhit[1]  = if_b.q_hit;
  assign d_qval[0]  = if_a.q_val;
  assign d_qval[1]  = if_b.q_val;

  typedef struct {
    bit          ready;
    int          cnt;
    int          nwr;
    logic [31:0] ret;
    logic [1:0]  qhit;
    logic [63:0] qval;
  } cyc_t;

  wb_wr_t      mbuf   [2][$];
  wb_wr_t      exp_wr [2][$];
  cyc_t        cycq   [2][$];
  int unsigned mret   [2];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic int wports(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  // Drive one cycle's inputs and let the model predict this cycle's outputs and the next edge.
  task automatic step(input bit rst_now, input logic [1:0] v, input logic [1:0] wr,
                      input logic [9:0] rn, input logic [63:0] rv, input logic [9:0] qr);
    reset     = rst_now;
    in_valid  = v;
    in_wr_reg = wr;
    in_wregno = rn;
    in_regval = rv;
    q_regno   = qr;
    for (int d = 0; d < 2; d++) begin
      cyc_t   e;
      int     n;
      bit     younger;
      wb_wr_t w;
      logic [4:0] r;
      e.ready = 1'b1; e.cnt = 0; e.nwr = 0; e.ret = '0; e.qhit = '0; e.qval = '0;
      if (rst_now) begin
        mbuf[d].delete();
        exp_wr[d].delete();
        mret[d] = 0;
      end else begin
        n = (mbuf[d].size() < wports(d)) ? mbuf[d].size() : wports(d);
        for (int p = 0; p < n; p++) begin
          younger = 1'b0;
          for (int y = p + 1; y < n; y++)
            if (mbuf[d][y].regno == mbuf[d][p].regno) younger = 1'b1;
          if (!younger) begin
            exp_wr[d].push_back(mbuf[d][p]);
            e.nwr++;
          end
        end
        e.cnt   = mbuf[d].size();
        e.ready = (4 - mbuf[d].size()) >= 2;
        e.ret   = mret[d];
        for (int q = 0; q < 2; q++) begin
          r = qr[q*5 +: 5];
          if (r != 5'd0)
            for (int i = 0; i < mbuf[d].size(); i++)
              if (mbuf[d][i].regno == r) begin
                e.qhit[q]        = 1'b1;
                e.qval[q*32 +: 32] = mbuf[d][i].val;
              end
        end
        repeat (n) void'(mbuf[d].pop_front());
        if (e.ready) begin
          for (int l = 0; l < 2; l++)
            if (v[l] && wr[l] && rn[l*5 +: 5] != 5'd0) begin
              w.regno = rn[l*5 +: 5];
              w.val   = rv[l*32 +: 32];
              mbuf[d].push_back(w);
            end
          mret[d] += $countones(v);
        end
      end
      cycq[d].push_back(e);
    end
  endtask

  task automatic cyc(input bit rst_now, input logic [1:0] v, input logic [1:0] wr,
                     input logic [9:0] rn, input logic [63:0] rv, input logic [9:0] qr);
    @(posedge clk);
    #1;
    step(rst_now, v, wr, rn, rv, qr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 2'b00, 2'b00, 10'd0, 64'd0,
          {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
  endtask

  // Monitor: one expectation per instance per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (cycq[d].size() != 0) begin
          cyc_t   e;
          wb_wr_t w;
          e = cycq[d].pop_front();
          check("in_ready", d, 32'(d_ready[d]), 32'(e.ready));
          check("buf_count", d, 32'(d_cnt[d]), 32'(e.cnt));
          check("retired_count", d, d_ret[d], e.ret);
          check("wr_strobes", d, 32'($countones(d_en[d])), 32'(e.nwr));
          for (int p = 0; p < 2; p++) begin
            if (d_en[d][p]) begin
              if (exp_wr[d].size() == 0) begin
                check("wr_unexpected", d, 32'(d_en[d][p]), 32'd0);
              end else begin
                w = exp_wr[d].pop_front();
                check("wr_regno", d, 32'(d_regno[d][p*5 +: 5]), 32'(w.regno));
                check("wr_val", d, d_val[d][p*32 +: 32], w.val);
              end
            end
          end
          for (int q = 0; q < 2; q++) begin
            check("q_hit", d, 32'(d_qhit[d][q]), 32'(e.qhit[q]));
            check("q_val", d, d_qval[d][q*32 +: 32], e.qval[q*32 +: 32]);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = '0; in_wr_reg = '0; in_wregno = '0; in_regval = '0; q_regno = '0;
    mret[0] = 0; mret[1] = 0;

    // Reset, then idle.
    repeat (2) cyc(1'b1, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0);
    repeat (2) cyc(1'b0, 2'b00, 2'b00, 10'd0, 64'd0, {5'd6, 5'd5});

    // Two writing lanes in one group.
    cyc(1'b0, 2'b11, 2'b11, {5'd6, 5'd5}, {32'hBBBB0002, 32'hAAAA0001}, 10'd0);
    idle(4);

    // Four back-to-back groups, each held until the single-port instance has room.
    for (int g = 0; g < 4; g++) begin
      for (int t = 0; t < 10 && (4 - mbuf[0].size()) < 2; t++) idle(1);
      cyc(1'b0, 2'b11, 2'b11,
          {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))},
          {$urandom(), $urandom()}, 10'd0);
    end
    idle(10);

    // x0 write and a non-writing lane: nothing buffered, both retire.
    cyc(1'b0, 2'b11, 2'b01, {5'd9, 5'd0}, {32'h00005555, 32'h00001234}, 10'd0);
    idle(2);

    // Same register twice: forwarding sees the younger, WPORTS=2 suppresses the older.
    cyc(1'b0, 2'b11, 2'b11, {5'd7, 5'd7}, {32'd2, 32'd1}, 10'd0);
    cyc(1'b0, 2'b00, 2'b00, 10'd0, 64'd0, {5'd8, 5'd7});
    idle(3);

    // Reset with entries pending (three in the single-port instance).
    cyc(1'b0, 2'b11, 2'b11, {5'd11, 5'd10}, {$urandom(), $urandom()}, 10'd0);
    cyc(1'b0, 2'b11, 2'b11, {5'd13, 5'd12}, {$urandom(), $urandom()}, {5'd12, 5'd10});
    cyc(1'b1, 2'b00, 2'b00, 10'd0, 64'd0, {5'd12, 5'd10});
    idle(3);

    // Random traffic with a small register range so collisions and x0 are common.
    for (int i = 0; i < 400; i++) begin
      if (i == 200)
        cyc(1'b1, 2'b00, 2'b00, 10'd0, 64'd0, 10'd0);
      else
        cyc(1'b0, 2'($urandom()), 2'($urandom()),
            {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
            {$urandom(), $urandom()},
            {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
    end

    for (int k = 0; k < 40 && (mbuf[0].size() != 0 || mbuf[1].size() != 0); k++) idle(1);
    idle(2);
    @(negedge clk);
    #1;
    check("undrained_writes", 0, 32'(exp_wr[0].size()), 32'd0);
    check("undrained_writes", 1, 32'(exp_wr[1].size()), 32'd0);
    check("final_buf_count", 0, 32'(cnt_a), 32'd0);
    check("final_buf_count", 1, 32'(cnt_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
